fdc_output_packer: RTL and testbench

- Sits directly downstream of the frequency-to-digital converter core inside tt_um_FDC_chip.
- Buffers each DATA_W-bit FDC result and streams it out MSB-first as a byte frame on an 8-bit valid/ready interface.
- The top level maps this byte stream onto uo_out and the uio handshake pins.
- Counts samples dropped on overflow so that host-side software can detect lost measurements.

---
 rtl/fdc_pkg.sv | 25 ++
 rtl/fdc_sample_fifo.sv | 59 +++++
 rtl/fdc_output_packer.sv | 170 +++++++++++++++++
 tb/tb_fdc_output_packer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// Shared types and constants for the FDC output path.
// The checksum byte is only used when FDC_OUT_CHECKSUM_EN is defined.
package fdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CHK  = 2'd2
  } state_t;

  localparam int DATA_W_DEFAULT     = 16;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam logic [7:0] OVF_MAX    = 8'hFF;

  // XOR of the low nbytes bytes of a sample (samples are at most 32 bits wide).
  function automatic logic [7:0] xor_checksum(input logic [31:0] word, input int nbytes);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i < nbytes) acc = acc ^ word[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/fdc_sample_fifo.sv
// Synchronous sample FIFO with a registered level and a synchronous flush.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module fdc_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fdc_output_packer.sv
// Buffers FDC samples and streams each one MSB-first as a byte frame on valid/ready.
// Define FDC_OUT_CHECKSUM_EN to append an XOR checksum byte to every frame.
module fdc_output_packer
  import fdc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [DATA_W-1:0]             sample_data,
  input  logic                          sample_valid,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    ovf_count,
  output logic                          busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              xfer;
  logic              last_data;
  logic              frame_done;
  logic              pop;
  logic              push;
  logic              drop;

  function automatic logic [7:0] byte_at(input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] i);
    return w[(NBYTES - 1 - int'(i)) * 8 +: 8];
  endfunction

  assign xfer      = out_valid && out_ready;
  assign last_data = (idx == LAST_IDX);
  assign idx_next  = idx + IDX_W'(1);

`ifdef FDC_OUT_CHECKSUM_EN
  logic [7:0] chk;
  assign frame_done = (state == CHK) && xfer;
`else
  assign frame_done = (state == SEND) && xfer && last_data;
`endif

  // Popping at the end of a frame is what gives bubble-free back-to-back frames.
  assign pop  = !clear && !fifo_empty && ((state == IDLE) || frame_done);
  assign push = sample_valid && !clear;
  assign drop = push && fifo_full && !pop;
  assign busy = (fifo_level != '0) || (state != IDLE);

  fdc_sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (push),
    .pop   (pop),
    .din   (sample_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef FDC_OUT_CHECKSUM_EN
      chk       <= '0;
`endif
    end else if (clear) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef FDC_OUT_CHECKSUM_EN
      chk       <= '0;
`endif
    end else if (pop) begin
      state     <= SEND;
      shreg     <= fifo_dout;
      idx       <= '0;
      out_data  <= fifo_dout[DATA_W-1 -: 8];
      out_valid <= 1'b1;
`ifdef FDC_OUT_CHECKSUM_EN
      out_last  <= 1'b0;
      chk       <= xor_checksum(32'(fifo_dout), NBYTES);
`else
      out_last  <= (NBYTES == 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
        SEND: begin
          if (xfer) begin
            if (!last_data) begin
              idx      <= idx_next;
              out_data <= byte_at(shreg, idx_next);
`ifdef FDC_OUT_CHECKSUM_EN
              out_last <= 1'b0;
`else
              out_last <= (idx_next == LAST_IDX);
`endif
            end else begin
`ifdef FDC_OUT_CHECKSUM_EN
              state    <= CHK;
              out_data <= chk;
              out_last <= 1'b1;
`else
              state     <= IDLE;
              out_data  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
`endif
            end
          end
        end
`ifdef FDC_OUT_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            state     <= IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (clear) begin
      ovf_count <= '0;
    end else if (drop && (ovf_count != OVF_MAX)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fdc_output_packer.sv
// Directed bench for fdc_output_packer (DATA_W=16, FIFO_DEPTH=4).
// Expected frames include the checksum byte when FDC_OUT_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_fdc_output_packer;

`ifdef FDC_OUT_CHECKSUM_EN
  localparam int FRAME_LEN = 3;
`else
  localparam int FRAME_LEN = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [2:0]  fifo_level;
  logic [7:0]  ovf_count;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;
  int coll_cycles = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];

  fdc_output_packer #(
    .DATA_W     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .fifo_level   (fifo_level),
    .ovf_count    (ovf_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Expected byte stream of one frame, MSB first, optional XOR trailer.
  task automatic add_frame(input logic [15:0] s);
    exp_data.push_back(s[15:8]); exp_last.push_back(1'b0);
    exp_data.push_back(s[7:0]);  exp_last.push_back(FRAME_LEN == 2);
    if (FRAME_LEN == 3) begin
      exp_data.push_back(s[15:8] ^ s[7:0]); exp_last.push_back(1'b1);
    end
  endtask

  // Records bytes with out_ready=1 starting at the current negedge.
  task automatic collect(input int n, input int max_cycles);
    got_data.delete(); got_last.delete(); coll_cycles = 0;
    out_ready = 1'b1;
    if (out_valid) begin got_data.push_back(out_data); got_last.push_back(out_last); end
    while (got_data.size() < n && coll_cycles < max_cycles) begin
      @(negedge clk);
      coll_cycles++;
      if (out_valid) begin got_data.push_back(out_data); got_last.push_back(out_last); end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; clear = 1'b0; sample_valid = 1'b0; out_ready = 1'b0; sample_data = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_out: valid=%b last=%b data=%h, expected 0 0 00", out_valid, out_last, out_data);
    end
    tests_run++;
    if (fifo_level !== 3'd0 || ovf_count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counts: level=%0d ovf=%0d, expected 0 0", fifo_level, ovf_count);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy: busy=%b, expected 0", busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    apply_reset();
    exp_data.delete(); exp_last.delete();
    add_frame(16'hBEEF);
    out_ready = 1'b1; sample_data = 16'hBEEF; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL single_n1: valid=%b level=%0d, expected 0 1", out_valid, fifo_level);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'hBE || out_last !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_n2: valid=%b data=%h last=%b, expected 1 be 0", out_valid, out_data, out_last);
    end
    collect(FRAME_LEN, 20);
    tests_run++;
    if (got_data.size() != exp_data.size()) begin
      tests_failed++;
      $display("[TB] FAIL single_count: got %0d bytes, expected %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        tests_failed++;
        $display("[TB] FAIL single_byte%0d: got %h last %b, expected %h last %b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_idle: valid=%b busy=%b, expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    exp_data.delete(); exp_last.delete();
    add_frame(16'h1234);
    out_ready = 1'b0; sample_data = 16'h1234; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h12 || out_last !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL stall_c%0d: valid=%b data=%h last=%b, expected 1 12 0", c, out_valid, out_data, out_last);
      end
      @(negedge clk);
    end
    collect(FRAME_LEN, 20);
    tests_run++;
    if (got_data.size() != exp_data.size()) begin
      tests_failed++;
      $display("[TB] FAIL stall_count: got %0d bytes, expected %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        tests_failed++;
        $display("[TB] FAIL stall_byte%0d: got %h last %b, expected %h last %b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  // Sample 1 moves to the shift register, 2..5 fill the FIFO, 6 and 7 are dropped.
  task automatic test_overflow();
    apply_reset();
    exp_data.delete(); exp_last.delete();
    for (int i = 1; i <= 5; i++) add_frame(16'(i));
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      sample_data = 16'(i); sample_valid = 1'b1;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    tests_run++;
    if (fifo_level !== 3'd4 || ovf_count !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL ovf_counts: level=%0d ovf=%0d, expected 4 2", fifo_level, ovf_count);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h00 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ovf_head: valid=%b data=%h busy=%b, expected 1 00 1", out_valid, out_data, busy);
    end
    collect(5 * FRAME_LEN, 60);
    tests_run++;
    if (got_data.size() != exp_data.size() || coll_cycles != 5 * FRAME_LEN - 1) begin
      tests_failed++;
      $display("[TB] FAIL ovf_stream: got %0d bytes in %0d cycles, expected %0d in %0d", got_data.size(), coll_cycles, exp_data.size(), 5 * FRAME_LEN - 1);
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        tests_failed++;
        $display("[TB] FAIL ovf_byte%0d: got %h last %b, expected %h last %b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || ovf_count !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL ovf_after: valid=%b level=%0d ovf=%0d, expected 0 0 2", out_valid, fifo_level, ovf_count);
    end
  endtask

  task automatic test_push_pop_full();
    apply_reset();
    exp_data.delete(); exp_last.delete();
    for (int i = 2; i <= 6; i++) add_frame(16'hA000 + 16'(i));
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      sample_data = 16'hA000 + 16'(i); sample_valid = 1'b1;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    tests_run++;
    if (fifo_level !== 3'd4 || ovf_count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL full_fill: level=%0d ovf=%0d, expected 4 0", fifo_level, ovf_count);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && !(out_valid && out_last); c++) @(negedge clk);
    tests_run++;
    if (!(out_valid === 1'b1 && out_last === 1'b1)) begin
      tests_failed++;
      $display("[TB] FAIL full_lastwait: valid=%b last=%b, expected 1 1 within 10 cycles", out_valid, out_last);
    end
    sample_data = 16'hA006; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    tests_run++;
    if (fifo_level !== 3'd4 || ovf_count !== 8'd0 || out_data !== 8'hA0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_pushpop: level=%0d ovf=%0d data=%h valid=%b, expected 4 0 a0 1", fifo_level, ovf_count, out_data, out_valid);
    end
    collect(5 * FRAME_LEN, 60);
    tests_run++;
    if (got_data.size() != exp_data.size()) begin
      tests_failed++;
      $display("[TB] FAIL full_count: got %0d bytes, expected %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        tests_failed++;
        $display("[TB] FAIL full_byte%0d: got %h last %b, expected %h last %b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_clear();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      sample_data = 16'h1100 + 16'(i); sample_valid = 1'b1;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    tests_run++;
    if (ovf_count !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL clear_pre_ovf: ovf=%0d, expected 2", ovf_count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; clear = 1'b1; sample_data = 16'hDEAD; sample_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; sample_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || ovf_count !== 8'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_state: valid=%b level=%0d ovf=%0d busy=%b, expected 0 0 0 0", out_valid, fifo_level, ovf_count, busy);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL clear_discard: valid=%b level=%0d, expected 0 0", out_valid, fifo_level);
    end
    exp_data.delete(); exp_last.delete();
    add_frame(16'hCAFE);
    out_ready = 1'b1; sample_data = 16'hCAFE; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    collect(FRAME_LEN, 20);
    tests_run++;
    if (got_data.size() != exp_data.size()) begin
      tests_failed++;
      $display("[TB] FAIL clear_count: got %0d bytes, expected %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        tests_failed++;
        $display("[TB] FAIL clear_byte%0d: got %h last %b, expected %h last %b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    out_ready = 1'b0; sample_data = 16'h5678; sample_valid = 1'b1;
    @(negedge clk);
    sample_data = 16'h9999;
    @(negedge clk);
    sample_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_level !== 3'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset: valid=%b data=%h level=%0d busy=%b, expected 0 00 0 0", out_valid, out_data, fifo_level, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_after: valid=%b level=%0d, expected 0 0", out_valid, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_push_pop_full();
    test_clear();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: still running at %0t, expected finish before 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
